// File: rtl/bcd_serial_frame_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_serial_frame_capture_if
// Description : Bundle of the serial bit/count inputs and the frame-status
//               outputs of the BCD serial frame capture block.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_serial_frame_capture_if #(
    parameter int FRAME_LEN = 10,
    parameter int CNT_W     = 4,
    parameter int FCNT_W    = 8
);
    logic                 BIT_IN;
    logic [CNT_W-1:0]     CNT_IN;
    logic [FRAME_LEN-1:0] FRAME;
    logic                 FRAME_VALID;
    logic [3:0]           ONES;
    logic                 SEQ_ERR;
    logic [FCNT_W-1:0]    FRAME_COUNT;
    logic                 LOCKED;

    // Upstream generator / testbench side
    modport master (
        output BIT_IN, CNT_IN,
        input  FRAME, FRAME_VALID, ONES, SEQ_ERR, FRAME_COUNT, LOCKED
    );

    // Capture block side
    modport slave (
        input  BIT_IN, CNT_IN,
        output FRAME, FRAME_VALID, ONES, SEQ_ERR, FRAME_COUNT, LOCKED
    );
endinterface
`default_nettype wire

// File: rtl/bcd_serial_frame_capture.sv
`default_nettype none
// ============================================================================
// Module      : bcd_serial_frame_capture
// Description : Samples a serial bit plus its BCD bit index each clock,
//               reassembles FRAME_LEN-bit frames, reports completion, ones
//               count and a wrapping frame counter, and flags / recovers from
//               loss of count sequence by resyncing on the next count of 0.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_frame_capture #(
    parameter int FRAME_LEN = 10,
    parameter int CNT_W     = 4,
    parameter int FCNT_W    = 8
) (
    input  wire logic                    CLK,
    input  wire logic                    RST,
    bcd_serial_frame_capture_if.slave    bus
);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_CAPTURE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(FRAME_LEN - 1);

    state_t               r_state;
    logic [FRAME_LEN-2:0] r_shadow;     // bits 0..FRAME_LEN-2; last bit goes straight to FRAME
    logic [3:0]           r_acc;
    logic [CNT_W-1:0]     r_exp;
    logic [FRAME_LEN-1:0] r_frame;
    logic                 r_frame_valid;
    logic [3:0]           r_ones;
    logic                 r_seq_err;
    logic [FCNT_W-1:0]    r_frame_count;

    logic [FRAME_LEN-2:0] w_shadow_set;
    logic [3:0]           w_bit_ext;

    assign w_bit_ext = {3'b000, bus.BIT_IN};

    // Shadow register with the bit addressed by CNT_IN replaced by BIT_IN
    always_comb begin
        w_shadow_set = r_shadow;
        for (int i = 0; i < FRAME_LEN - 1; i++) begin
            if (bus.CNT_IN == CNT_W'(i)) begin
                w_shadow_set[i] = bus.BIT_IN;
            end
        end
    end

    // Frame capture state machine with registered status outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state       <= S_IDLE;
            r_shadow      <= '0;
            r_acc         <= '0;
            r_exp         <= '0;
            r_frame       <= '0;
            r_frame_valid <= 1'b0;
            r_ones        <= '0;
            r_seq_err     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            r_seq_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Only a count of 0 can start a frame; anything else is ignored silently
                    if (bus.CNT_IN == '0) begin
                        r_shadow <= {{(FRAME_LEN-2){1'b0}}, bus.BIT_IN};
                        r_acc    <= w_bit_ext;
                        r_exp    <= CNT_W'(1);
                        r_state  <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (bus.CNT_IN == r_exp) begin
                        if (r_exp == '0) begin
                            // Back-to-back frame start, identical to leaving IDLE
                            r_shadow <= {{(FRAME_LEN-2){1'b0}}, bus.BIT_IN};
                            r_acc    <= w_bit_ext;
                            r_exp    <= CNT_W'(1);
                        end else if (bus.CNT_IN == c_LAST_CNT) begin
                            r_frame       <= {bus.BIT_IN, r_shadow};
                            r_ones        <= r_acc + w_bit_ext;
                            r_frame_count <= r_frame_count + FCNT_W'(1);
                            r_frame_valid <= 1'b1;
                            r_exp         <= '0;
                        end else begin
                            r_shadow <= w_shadow_set;
                            r_acc    <= r_acc + w_bit_ext;
                            r_exp    <= bus.CNT_IN + CNT_W'(1);
                        end
                    end else begin
                        // Sequence lost: drop the partial frame; a 0 here does not resync
                        r_seq_err <= 1'b1;
                        r_shadow  <= '0;
                        r_acc     <= '0;
                        r_exp     <= '0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.FRAME       = r_frame;
    assign bus.FRAME_VALID = r_frame_valid;
    assign bus.ONES        = r_ones;
    assign bus.SEQ_ERR     = r_seq_err;
    assign bus.FRAME_COUNT = r_frame_count;
    assign bus.LOCKED      = (r_state == S_CAPTURE);

endmodule
`default_nettype wire
